i2c_reg_ctrl: RTL and testbench

I2C_REG_CTRL -- requirements
Module: i2c_reg_ctrl

---
 rtl/i2c_state_pkg.sv | 16 +
 rtl/i2c_rr_arb2.sv | 34 +++
 rtl/i2c_reg_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_reg_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_state_pkg.sv
// Shared types and widths for the I2C register-access controller.
package i2c_state_pkg;

  localparam int PTR_W  = 8;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    GET_PTR,
    WR_DATA,
    RD_FETCH,
    RD_WAIT,
    RD_HOLD
  } reg_ctrl_state_t;

endpackage

// File: rtl/i2c_rr_arb2.sv
// Two-requester round-robin arbiter; grant is combinational, last-winner is registered.
module i2c_rr_arb2
  import i2c_state_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_gnt_a,
  output logic o_gnt_b
);

  logic r_last_b;
  logic w_gnt_a;
  logic w_gnt_b;

  // On a tie, the side that did not win last time gets the slot.
  assign w_gnt_a = i_req_a & (~i_req_b | r_last_b);
  assign w_gnt_b = i_req_b & ~w_gnt_a;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_b <= 1'b1;
    end else if (w_gnt_a) begin
      r_last_b <= 1'b0;
    end else if (w_gnt_b) begin
      r_last_b <= 1'b1;
    end
  end

  assign o_gnt_a = w_gnt_a;
  assign o_gnt_b = w_gnt_b;

endmodule

// File: rtl/i2c_reg_ctrl.sv
// Bridges I2C subordinate byte traffic and a local host onto one register-file port.
//   state    | meaning
//   IDLE     | no transaction
//   GET_PTR  | write txn, waiting for register pointer byte
//   WR_DATA  | write txn, each byte goes to the pending-write buffer
//   RD_FETCH | read txn, requesting rf read at ptr
//   RD_WAIT  | read granted, rf_rdata arrives this cycle
//   RD_HOLD  | tx_byte valid, waiting for the subordinate to consume it
module i2c_reg_ctrl
  import i2c_state_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              txn_start,
  input  logic              txn_rw,
  input  logic              txn_stop,
  input  logic              rx_byte_valid,
  input  logic [DATA_W-1:0] rx_byte,
  input  logic              tx_byte_req,
  output logic [DATA_W-1:0] tx_byte,
  output logic              tx_valid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [PTR_W-1:0]  host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic              rf_en,
  output logic              rf_we,
  output logic [PTR_W-1:0]  rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              i2c_busy,
  output logic              rx_overrun,
  output logic              tx_underrun
);

  reg_ctrl_state_t r_state;
  reg_ctrl_state_t w_state_nxt;

  logic [PTR_W-1:0]  r_ptr;
  logic              r_wr_pend;
  logic [PTR_W-1:0]  r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [DATA_W-1:0] r_tx_byte;
  logic              r_tx_valid;
  logic              r_host_rvalid;
  logic              r_rx_overrun;
  logic              r_tx_underrun;

  logic w_ld_ptr;
  logic w_capture;
  logic w_overrun;
  logic w_underrun;
  logic w_tx_load;
  logic w_tx_clr;
  logic w_rd_adv;
  logic w_i2c_req;
  logic w_host_req;
  logic w_gnt_i2c;
  logic w_gnt_host;
  logic w_wr_gnt;
  logic w_rd_gnt;

  // Pending writes go ahead of a read fetch so a read sees the bytes just written.
  // Requests are masked during reset so nothing strobes the register file.
  assign w_i2c_req  = rst_n & (r_wr_pend | (r_state == RD_FETCH));
  assign w_host_req = rst_n & host_req;
  assign w_wr_gnt   = w_gnt_i2c & r_wr_pend;
  assign w_rd_gnt   = w_gnt_i2c & ~r_wr_pend;

  i2c_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req_a (w_i2c_req),
    .i_req_b (w_host_req),
    .o_gnt_a (w_gnt_i2c),
    .o_gnt_b (w_gnt_host)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ld_ptr    = 1'b0;
    w_capture   = 1'b0;
    w_overrun   = 1'b0;
    w_underrun  = 1'b0;
    w_tx_load   = 1'b0;
    w_tx_clr    = 1'b0;
    w_rd_adv    = 1'b0;
    if (tx_byte_req && (r_state != RD_HOLD)) begin
      w_underrun = 1'b1;
    end
    if (txn_start) begin
      w_state_nxt = txn_rw ? RD_FETCH : GET_PTR;
      w_tx_clr    = 1'b1;
    end else if (txn_stop) begin
      w_state_nxt = IDLE;
      w_tx_clr    = 1'b1;
    end else begin
      case (r_state)
        GET_PTR: begin
          if (rx_byte_valid) begin
            w_ld_ptr    = 1'b1;
            w_state_nxt = WR_DATA;
          end
        end
        WR_DATA: begin
          if (rx_byte_valid) begin
            if (r_wr_pend) begin
              w_overrun = 1'b1;
            end else begin
              w_capture = 1'b1;
            end
          end
        end
        RD_FETCH: begin
          if (w_rd_gnt) begin
            w_state_nxt = RD_WAIT;
          end
        end
        RD_WAIT: begin
          w_tx_load   = 1'b1;
          w_state_nxt = RD_HOLD;
        end
        RD_HOLD: begin
          if (tx_byte_req) begin
            w_tx_clr    = 1'b1;
            w_rd_adv    = 1'b1;
            w_state_nxt = RD_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr         <= '0;
      r_wr_pend     <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_tx_byte     <= '0;
      r_tx_valid    <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_rx_overrun  <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      if (w_ld_ptr) begin
        r_ptr <= rx_byte;
      end else if (w_wr_gnt || w_rd_adv) begin
        r_ptr <= r_ptr + PTR_W'(1);
      end
      if (w_capture) begin
        r_wr_pend <= 1'b1;
        r_wr_addr <= r_ptr;
        r_wr_data <= rx_byte;
      end else if (w_wr_gnt) begin
        r_wr_pend <= 1'b0;
      end
      if (w_tx_clr) begin
        r_tx_valid <= 1'b0;
      end else if (w_tx_load) begin
        r_tx_byte  <= rf_rdata;
        r_tx_valid <= 1'b1;
      end
      r_host_rvalid <= w_gnt_host & ~host_we;
      r_rx_overrun  <= w_overrun;
      r_tx_underrun <= w_underrun;
    end
  end

  always_comb begin
    rf_en    = w_gnt_i2c | w_gnt_host;
    rf_we    = 1'b0;
    rf_addr  = '0;
    rf_wdata = '0;
    if (w_gnt_host) begin
      rf_we    = host_we;
      rf_addr  = host_addr;
      rf_wdata = host_wdata;
    end else if (w_wr_gnt) begin
      rf_we    = 1'b1;
      rf_addr  = r_wr_addr;
      rf_wdata = r_wr_data;
    end else if (w_rd_gnt) begin
      rf_addr  = r_ptr;
    end
  end

  assign host_gnt    = w_gnt_host;
  assign host_rvalid = r_host_rvalid;
  assign tx_byte     = r_tx_byte;
  assign tx_valid    = r_tx_valid;
  assign i2c_busy    = (r_state != IDLE);
  assign rx_overrun  = r_rx_overrun;
  assign tx_underrun = r_tx_underrun;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Scoreboard bench for i2c_reg_ctrl: directed corner cases, then concurrent random I2C and host traffic.
module tb_i2c_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       txn_start, txn_rw, txn_stop, rx_byte_valid, tx_byte_req;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       host_req, host_we;
  logic [7:0] host_addr, host_wdata;
  logic       host_gnt, host_rvalid;
  logic       rf_en, rf_we;
  logic [7:0] rf_addr, rf_wdata;
  logic [7:0] rf_rdata;
  logic       i2c_busy, rx_overrun, tx_underrun;

  i2c_reg_ctrl dut (
    .clk(clk), .rst_n(rst_n), .txn_start(txn_start), .txn_rw(txn_rw), .txn_stop(txn_stop),
    .rx_byte_valid(rx_byte_valid), .rx_byte(rx_byte), .tx_byte_req(tx_byte_req),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .rf_en(rf_en), .rf_we(rf_we), .rf_addr(rf_addr),
    .rf_wdata(rf_wdata), .rf_rdata(rf_rdata), .i2c_busy(i2c_busy),
    .rx_overrun(rx_overrun), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;

  logic [7:0] mem [256];      // register file behind the DUT
  logic [7:0] exp_mem [256];  // reference view of register contents
  logic [7:0] m_ptr;          // reference register pointer
  wr_t        i2c_wq[$], host_wq[$];
  logic [7:0] host_rq[$], tx_q[$];
  int checks = 0, errors = 0;
  int exp_ovr = 0, obs_ovr = 0, exp_unr = 0, obs_unr = 0;
  logic prev_tv = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rf_en) begin
      if (rf_we) mem[rf_addr] <= rf_wdata;
      else       rf_rdata     <= mem[rf_addr];
    end
  end

  // Monitor: pops expectations whenever the DUT presents a result.
  always @(negedge clk) begin
    wr_t w;
    logic [7:0] e;
    if (rst_n) begin
      if (rf_en && rf_we) begin
        if (rf_addr >= 8'hE0) begin
          if (host_wq.size() == 0) chk("host_wr_unexpected", {rf_addr, rf_wdata}, 0);
          else begin w = host_wq.pop_front(); chk("host_wr", {rf_addr, rf_wdata}, {w.a, w.d}); end
        end else begin
          if (i2c_wq.size() == 0) chk("i2c_wr_unexpected", {rf_addr, rf_wdata}, 0);
          else begin w = i2c_wq.pop_front(); chk("i2c_wr", {rf_addr, rf_wdata}, {w.a, w.d}); end
        end
      end
      if (host_rvalid) begin
        if (host_rq.size() == 0) chk("host_rd_unexpected", rf_rdata, 256);
        else begin e = host_rq.pop_front(); chk("host_rdata", rf_rdata, e); end
      end
      if (tx_valid && !prev_tv) begin
        if (tx_q.size() == 0) chk("tx_unexpected", tx_byte, 256);
        else begin e = tx_q.pop_front(); chk("tx_byte", tx_byte, e); end
      end
      if (rx_overrun)  obs_ovr++;
      if (tx_underrun) obs_unr++;
    end
    prev_tv = tx_valid;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input bit rw);
    txn_start = 1'b1; txn_rw = rw; tick(); txn_start = 1'b0; txn_rw = 1'b0;
  endtask

  task automatic pulse_stop();
    txn_stop = 1'b1; tick(); txn_stop = 1'b0;
  endtask

  task automatic i2c_send(input logic [7:0] b);
    rx_byte_valid = 1'b1; rx_byte = b; tick(); rx_byte_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic i2c_wbyte(input logic [7:0] d);
    i2c_wq.push_back({m_ptr, d});
    exp_mem[m_ptr] = d;
    m_ptr++;
    i2c_send(d);
  endtask

  task automatic i2c_read(input int n, input bit stop, output int lat);
    int cnt;
    lat = 0;
    for (int k = 0; k < n; k++) tx_q.push_back(exp_mem[8'(m_ptr + k)]);
    pulse_start(1'b1);
    for (int k = 0; k < n; k++) begin
      cnt = 0;
      while (!tx_valid && cnt < 20) begin tick(); cnt++; end
      if (k == 0) lat = cnt;
      if (!tx_valid) chk("tx_valid_timeout", 0, 1);
      tx_byte_req = 1'b1; tick(); tx_byte_req = 1'b0;
    end
    m_ptr = 8'(m_ptr + n);
    if (stop) pulse_stop();
  endtask

  task automatic host_op(input bit we, input logic [7:0] a, input logic [7:0] d);
    int n;
    host_we = we; host_addr = a; host_wdata = d;
    if (we) begin host_wq.push_back({a, d}); exp_mem[a] = d; end
    else host_rq.push_back(exp_mem[a]);
    host_req = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (host_gnt) break;
      n++;
      if (n > 10) begin chk("host_gnt_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    host_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i) ^ 8'h5A;
      exp_mem[i] = 8'(i) ^ 8'h5A;
    end
    m_ptr = 8'h00;
    rst_n = 1'b0; txn_start = 0; txn_rw = 0; txn_stop = 0; rx_byte_valid = 0; rx_byte = 0;
    tx_byte_req = 0; host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {tx_valid, host_gnt, host_rvalid, rf_en, rf_we, i2c_busy, rx_overrun, tx_underrun}, 0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    // Arbitration alternation and overrun under host contention
    pulse_start(1'b0);
    chk("busy_after_start", i2c_busy, 1);
    i2c_send(8'h30);
    m_ptr = 8'h30;
    i2c_wq.push_back({8'h30, 8'h11}); exp_mem[8'h30] = 8'h11;
    rx_byte_valid = 1'b1; rx_byte = 8'h11; tick();
    rx_byte_valid = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'hE1; host_rq.push_back(exp_mem[8'hE1]);
    @(negedge clk); chk("arb1_i2c", {rf_en, rf_we, host_gnt}, 3'b110);
    @(posedge clk); #1;
    @(negedge clk); chk("arb2_host", {rf_en, rf_we, host_gnt}, 3'b101);
    @(posedge clk); #1;
    host_req = 1'b0;
    i2c_wq.push_back({8'h31, 8'h22}); exp_mem[8'h31] = 8'h22;
    rx_byte_valid = 1'b1; rx_byte = 8'h22;
    @(negedge clk); chk("rvalid_after_gnt1", {host_rvalid, rf_en}, 2'b10);
    @(posedge clk); #1;
    rx_byte = 8'h99; exp_ovr++;
    host_req = 1'b1; host_addr = 8'hE2; host_rq.push_back(exp_mem[8'hE2]);
    @(negedge clk); chk("arb3_i2c", {rf_en, rf_we, host_gnt}, 3'b110);
    @(posedge clk); #1;
    rx_byte_valid = 1'b0;
    @(negedge clk); chk("arb4_host", {rf_en, rf_we, host_gnt}, 3'b101);
    chk("overrun_pulse", rx_overrun, 1);
    @(posedge clk); #1;
    host_req = 1'b0;
    @(negedge clk); chk("overrun_one_cycle", rx_overrun, 0);
    chk("rvalid_after_gnt2", host_rvalid, 1);
    m_ptr = 8'h32;
    @(posedge clk); #1;
    pulse_stop();
    i2c_read(1, 1'b1, lat);

    // Write 0x10 <- AA, BB then confirm pointer landed on 0x12
    pulse_start(1'b0); i2c_send(8'h10); m_ptr = 8'h10;
    i2c_wbyte(8'hAA); i2c_wbyte(8'hBB);
    pulse_stop();
    i2c_read(1, 1'b1, lat);

    // Pointer wrap on read from 0xFF
    pulse_start(1'b0); i2c_send(8'hFF); m_ptr = 8'hFF; pulse_stop();
    i2c_read(2, 1'b1, lat);
    i2c_read(1, 1'b1, lat);

    // Repeated start read after setting the pointer
    pulse_start(1'b0); i2c_send(8'h20); m_ptr = 8'h20;
    i2c_read(1, 1'b1, lat);
    chk("rd_latency_le2", (lat <= 2) ? 1 : 0, 1);

    // Underrun while idle
    tx_byte_req = 1'b1; tick(); tx_byte_req = 1'b0; exp_unr++;
    @(negedge clk); chk("underrun_pulse", tx_underrun, 1);
    chk("underrun_no_state_change", i2c_busy, 0);
    @(posedge clk); #1;

    // Reset during RD_WAIT
    pulse_start(1'b1); tick();
    rst_n = 1'b0;
    @(negedge clk); chk("rst_rdwait_no_rf_en", rf_en, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("rst_rdwait_idle", {tx_valid, i2c_busy, rf_en}, 0);
    m_ptr = 8'h00;
    @(posedge clk); #1;
    i2c_read(1, 1'b1, lat);

    // Random concurrent traffic
    fork
      begin
        repeat (14) begin
          logic [7:0] p;
          int n;
          p = 8'($urandom_range(0, 8'hB0));
          n = $urandom_range(1, 6);
          pulse_start(1'b0); i2c_send(p); m_ptr = p;
          if ($urandom_range(0, 1) == 1) begin
            for (int k = 0; k < n; k++) i2c_wbyte(8'($urandom));
            pulse_stop();
          end else begin
            i2c_read(n, 1'b1, lat);
          end
          repeat ($urandom_range(0, 3)) tick();
        end
      end
      begin
        repeat (40) begin
          repeat ($urandom_range(0, 4)) tick();
          host_op(1'($urandom), 8'hE0 + 8'($urandom_range(0, 15)), 8'($urandom));
        end
      end
    join

    repeat (10) tick();
    chk("i2c_wq_empty", i2c_wq.size(), 0);
    chk("host_wq_empty", host_wq.size(), 0);
    chk("host_rq_empty", host_rq.size(), 0);
    chk("tx_q_empty", tx_q.size(), 0);
    chk("overrun_count", obs_ovr, exp_ovr);
    chk("underrun_count", obs_unr, exp_unr);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
